// File: rtl/nmr_pkg.sv
// Shared types and default widths for the NMR echo packer.
// The FSM state enum lives here so the bench and any future blocks agree on encoding.
package nmr_pkg;

  localparam int DEF_ADC_DATA_WIDTH         = 16;
  localparam int DEF_SAMPLES_PER_ECHO_WIDTH = 32;
  localparam int DEF_ECHO_PER_SCAN_WIDTH    = 32;
  localparam int DEF_FIFO_DEPTH             = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/nmr_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous reset.
// A write into an empty FIFO is visible on rd_data the following cycle.
module nmr_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  // When full, a write is still taken if a read frees the head slot in the same cycle.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (AW+1)'(DEPTH));
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/nmr_echo_packer.sv
// Packs pairs of ADC samples into 2x-wide words tagged with echo/scan boundaries,
// buffered in an FWFT FIFO with a sticky overflow flag for dropped words.
module nmr_echo_packer
  import nmr_pkg::*;
#(
  parameter int ADC_DATA_WIDTH         = DEF_ADC_DATA_WIDTH,
  parameter int SAMPLES_PER_ECHO_WIDTH = DEF_SAMPLES_PER_ECHO_WIDTH,
  parameter int ECHO_PER_SCAN_WIDTH    = DEF_ECHO_PER_SCAN_WIDTH,
  parameter int FIFO_DEPTH             = DEF_FIFO_DEPTH
) (
  input  logic                              ADC_CLK,
  input  logic                              RESET,
  input  logic                              START,
  input  logic [SAMPLES_PER_ECHO_WIDTH-1:0] SAMPLES_PER_ECHO,
  input  logic [ECHO_PER_SCAN_WIDTH-1:0]    ECHO_PER_SCAN,
  input  logic [ADC_DATA_WIDTH-1:0]         ADC_IN_DATA,
  input  logic                              ADC_IN_VALID,
  output logic [2*ADC_DATA_WIDTH-1:0]       OUT_DATA,
  output logic                              OUT_LAST_ECHO,
  output logic                              OUT_LAST_SCAN,
  output logic                              OUT_VALID,
  input  logic                              OUT_READY,
  output logic                              BUSY,
  output logic                              OVERFLOW
);

  localparam int DW = 2 * ADC_DATA_WIDTH;
  localparam logic [SAMPLES_PER_ECHO_WIDTH-1:0] SPE_ONE = 1;
  localparam logic [ECHO_PER_SCAN_WIDTH-1:0]    EPS_ONE = 1;

  state_t                            state_q, state_d;
  logic [SAMPLES_PER_ECHO_WIDTH-1:0] spe_q, spe_d, smp_cnt_q, smp_cnt_d;
  logic [ECHO_PER_SCAN_WIDTH-1:0]    eps_q, eps_d, echo_cnt_q, echo_cnt_d;
  logic [ADC_DATA_WIDTH-1:0]         held_q, held_d;
  logic                              overflow_q, overflow_d;

  logic          push, pop, last_smp, last_echo;
  logic [DW+1:0] push_word, fifo_dout;
  logic          fifo_full, fifo_empty;

  assign OUT_VALID     = !fifo_empty;
  assign pop           = OUT_VALID && OUT_READY;
  assign OUT_DATA      = fifo_dout[DW-1:0];
  assign OUT_LAST_ECHO = fifo_dout[DW];
  assign OUT_LAST_SCAN = fifo_dout[DW+1];
  assign BUSY          = (state_q != IDLE);
  assign OVERFLOW      = overflow_q;

  always_comb begin
    state_d    = state_q;
    spe_d      = spe_q;
    eps_d      = eps_q;
    smp_cnt_d  = smp_cnt_q;
    echo_cnt_d = echo_cnt_q;
    held_d     = held_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    push_word  = '0;
    last_smp   = (smp_cnt_q == spe_q - SPE_ONE);
    last_echo  = (echo_cnt_q == eps_q - EPS_ONE);

    case (state_q)
      IDLE: begin
        if (START && (SAMPLES_PER_ECHO != '0) && (ECHO_PER_SCAN != '0)) begin
          state_d    = COLLECT;
          spe_d      = SAMPLES_PER_ECHO;
          eps_d      = ECHO_PER_SCAN;
          smp_cnt_d  = '0;
          echo_cnt_d = '0;
          held_d     = '0;
          overflow_d = 1'b0;
        end
      end
      COLLECT: begin
        if (ADC_IN_VALID) begin
          push = smp_cnt_q[0] || last_smp;
          // Word layout in the FIFO: {last_scan, last_echo, data}.
          push_word = {last_smp && last_echo, last_smp,
                       smp_cnt_q[0] ? {ADC_IN_DATA, held_q}
                                    : {{ADC_DATA_WIDTH{1'b0}}, ADC_IN_DATA}};
          if (!smp_cnt_q[0]) begin
            held_d = ADC_IN_DATA;
          end
          if (last_smp) begin
            smp_cnt_d  = '0;
            echo_cnt_d = echo_cnt_q + EPS_ONE;
            if (last_echo) begin
              state_d = DRAIN;
            end
          end else begin
            smp_cnt_d = smp_cnt_q + SPE_ONE;
          end
          if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ADC_CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      spe_q      <= '0;
      eps_q      <= '0;
      smp_cnt_q  <= '0;
      echo_cnt_q <= '0;
      held_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      spe_q      <= spe_d;
      eps_q      <= eps_d;
      smp_cnt_q  <= smp_cnt_d;
      echo_cnt_q <= echo_cnt_d;
      held_q     <= held_d;
      overflow_q <= overflow_d;
    end
  end

  nmr_sync_fifo #(
    .WIDTH (DW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ADC_CLK),
    .rst     (RESET),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (OUT_READY),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_nmr_echo_packer.sv
// Self-checking bench for nmr_echo_packer: vector table of whole scans plus
// hand-written overflow, zero-count, full-FIFO and mid-scan reset sequences.
module tb_nmr_echo_packer;

  logic        clk = 1'b0;
  logic        RESET, START, ADC_IN_VALID, OUT_READY;
  logic [31:0] SAMPLES_PER_ECHO, ECHO_PER_SCAN;
  logic [15:0] ADC_IN_DATA;
  logic [31:0] OUT_DATA;
  logic        OUT_LAST_ECHO, OUT_LAST_SCAN, OUT_VALID, BUSY, OVERFLOW;

  always #5 clk = ~clk;

  nmr_echo_packer #(
    .ADC_DATA_WIDTH         (16),
    .SAMPLES_PER_ECHO_WIDTH (32),
    .ECHO_PER_SCAN_WIDTH    (32),
    .FIFO_DEPTH             (16)
  ) dut (
    .ADC_CLK          (clk),
    .RESET            (RESET),
    .START            (START),
    .SAMPLES_PER_ECHO (SAMPLES_PER_ECHO),
    .ECHO_PER_SCAN    (ECHO_PER_SCAN),
    .ADC_IN_DATA      (ADC_IN_DATA),
    .ADC_IN_VALID     (ADC_IN_VALID),
    .OUT_DATA         (OUT_DATA),
    .OUT_LAST_ECHO    (OUT_LAST_ECHO),
    .OUT_LAST_SCAN    (OUT_LAST_SCAN),
    .OUT_VALID        (OUT_VALID),
    .OUT_READY        (OUT_READY),
    .BUSY             (BUSY),
    .OVERFLOW         (OVERFLOW)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        le;
    logic        ls;
  } word_t;

  typedef struct {
    int          spe;
    int          eps;
    logic [15:0] base;
    int          ready_mode;  // 0: always ready, 1: toggling
    bit          gaps;
    int          exp_words;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  word_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  int          got_cnt = 0;
  logic [31:0] got_first, got_last;

  int          m_idx, m_echo, m_words, m_keep;
  logic [15:0] m_held;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%08h while none expected", OUT_DATA);
      end else begin
        word_t e;
        e = sb.pop_front();
        chk("word_data", {32'd0, OUT_DATA}, {32'd0, e.data});
        chk("word_last_echo", {63'd0, OUT_LAST_ECHO}, {63'd0, e.le});
        chk("word_last_scan", {63'd0, OUT_LAST_SCAN}, {63'd0, e.ls});
        if (got_cnt == 0) got_first = OUT_DATA;
        got_last = OUT_DATA;
        got_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(logic [15:0] s, int spe, int eps);
    bit    last;
    word_t w;
    last = (m_idx == spe - 1);
    ADC_IN_VALID = 1'b1;
    ADC_IN_DATA  = s;
    if ((m_idx % 2 == 1) || last) begin
      w.data = (m_idx % 2 == 1) ? {s, m_held} : {16'h0000, s};
      w.le   = last;
      w.ls   = last && (m_echo == eps - 1);
      if (m_words < m_keep) sb.push_back(w);
      m_words++;
    end else begin
      m_held = s;
    end
    if (last) begin
      m_idx = 0;
      m_echo++;
    end else begin
      m_idx++;
    end
    tick();
  endtask

  task automatic start_scan(int spe, int eps);
    SAMPLES_PER_ECHO = spe;
    ECHO_PER_SCAN    = eps;
    START            = 1'b1;
    ADC_IN_VALID     = 1'b0;
    tick();
    START   = 1'b0;
    m_idx   = 0;
    m_echo  = 0;
    m_words = 0;
    m_keep  = 1 << 30;
    got_cnt = 0;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    ADC_IN_VALID = 1'b0;
    OUT_READY    = 1'b1;
    while (BUSY === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk(name, {63'd0, BUSY}, 64'd0);
    chk("scoreboard_drained", sb.size(), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int   bad;

    vecs[0] = '{4, 2, 16'd100,  0, 1'b0, 4, 32'h00650064, 32'h006B006A};
    vecs[1] = '{3, 1, 16'd1,    0, 1'b0, 2, 32'h00020001, 32'h00000003};
    vecs[2] = '{5, 2, 16'h0010, 1, 1'b1, 6, 32'h00110010, 32'h00000019};
    vecs[3] = '{1, 3, 16'h00A0, 1, 1'b0, 3, 32'h000000A0, 32'h000000A2};
    vecs[4] = '{2, 1, 16'hFFFE, 0, 1'b1, 1, 32'hFFFFFFFE, 32'hFFFFFFFE};

    RESET = 1'b1; START = 1'b0; ADC_IN_VALID = 1'b0; OUT_READY = 1'b0;
    ADC_IN_DATA = '0; SAMPLES_PER_ECHO = '0; ECHO_PER_SCAN = '0;
    tick();
    tick();
    RESET = 1'b0;
    chk("reset_out_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("reset_busy", {63'd0, BUSY}, 64'd0);
    chk("reset_overflow", {63'd0, OVERFLOW}, 64'd0);
    chk("reset_out_data", {32'd0, OUT_DATA}, 64'd0);
    chk("reset_tags", {62'd0, OUT_LAST_SCAN, OUT_LAST_ECHO}, 64'd0);

    for (int v = 0; v < 5; v++) begin
      OUT_READY = 1'b1;
      start_scan(vecs[v].spe, vecs[v].eps);
      chk("scan_busy", {63'd0, BUSY}, 64'd1);
      for (int k = 0; k < vecs[v].spe * vecs[v].eps; k++) begin
        if (vecs[v].gaps && (k % 3 == 2)) begin
          ADC_IN_VALID = 1'b0;
          ADC_IN_DATA  = 16'hDEAD;
          if (vecs[v].ready_mode == 1) OUT_READY = ~OUT_READY;
          tick();
        end
        if (vecs[v].ready_mode == 1) OUT_READY = ~OUT_READY;
        drive_sample(16'(int'(vecs[v].base) + k), vecs[v].spe, vecs[v].eps);
      end
      wait_idle("scan_idle");
      chk("scan_word_count", got_cnt, vecs[v].exp_words);
      chk("scan_first_word", {32'd0, got_first}, {32'd0, vecs[v].exp_first});
      chk("scan_last_word", {32'd0, got_last}, {32'd0, vecs[v].exp_last});
      chk("scan_overflow", {63'd0, OVERFLOW}, 64'd0);
      $display("vector %0d: spe=%0d eps=%0d words=%0d", v, vecs[v].spe, vecs[v].eps, got_cnt);
    end

    // Overflow: 20 words produced into a 16-deep FIFO with no reader.
    OUT_READY = 1'b0;
    start_scan(40, 1);
    m_keep = 16;
    for (int k = 0; k < 40; k++) drive_sample(16'(k), 40, 1);
    ADC_IN_VALID = 1'b0;
    tick();
    chk("ovf_out_valid", {63'd0, OUT_VALID}, 64'd1);
    chk("ovf_flag", {63'd0, OVERFLOW}, 64'd1);
    chk("ovf_busy_drain", {63'd0, BUSY}, 64'd1);
    wait_idle("ovf_idle");
    chk("ovf_word_count", got_cnt, 64'd16);
    chk("ovf_last_word", {32'd0, got_last}, 64'h001F001E);
    $display("overflow sequence: words=%0d overflow=%0b", got_cnt, OVERFLOW);

    // Zero counts: STARTs ignored, OVERFLOW left untouched.
    SAMPLES_PER_ECHO = 0; ECHO_PER_SCAN = 3; START = 1'b1;
    tick();
    SAMPLES_PER_ECHO = 5; ECHO_PER_SCAN = 0;
    tick();
    START = 1'b0;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      ADC_IN_VALID = 1'b1;
      ADC_IN_DATA  = 16'(k);
      tick();
      if (BUSY !== 1'b0 || OUT_VALID !== 1'b0) bad++;
    end
    ADC_IN_VALID = 1'b0;
    chk("zero_count_idle_cycles", bad, 64'd0);
    chk("zero_count_overflow_kept", {63'd0, OVERFLOW}, 64'd1);
    $display("zero-count sequence: bad_cycles=%0d", bad);

    // Full FIFO with ready toggling so every push lands on a pop.
    OUT_READY = 1'b0;
    start_scan(64, 1);
    chk("full_start_clears_ovf", {63'd0, OVERFLOW}, 64'd0);
    for (int k = 0; k < 64; k++) begin
      OUT_READY = (k >= 32) ? 1'(k % 2) : 1'b0;
      drive_sample(16'(16'h0200 + k), 64, 1);
    end
    chk("full_overflow", {63'd0, OVERFLOW}, 64'd0);
    wait_idle("full_idle");
    chk("full_word_count", got_cnt, 64'd32);
    $display("full-fifo sequence: words=%0d overflow=%0b", got_cnt, OVERFLOW);

    // Mid-scan reset, asserted together with START and a valid sample.
    OUT_READY = 1'b0;
    start_scan(8, 1);
    for (int k = 0; k < 5; k++) drive_sample(16'(16'h0300 + k), 8, 1);
    chk("rst_pre_out_valid", {63'd0, OUT_VALID}, 64'd1);
    RESET = 1'b1; START = 1'b1; ADC_IN_VALID = 1'b1;
    SAMPLES_PER_ECHO = 3; ECHO_PER_SCAN = 1;
    tick();
    RESET = 1'b0; START = 1'b0; ADC_IN_VALID = 1'b0;
    sb.delete();
    chk("rst_out_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("rst_busy", {63'd0, BUSY}, 64'd0);
    chk("rst_tags", {62'd0, OUT_LAST_SCAN, OUT_LAST_ECHO}, 64'd0);
    OUT_READY = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ADC_IN_VALID = 1'b1;
      ADC_IN_DATA  = 16'(k);
      tick();
    end
    chk("rst_no_stray_valid", {63'd0, OUT_VALID}, 64'd0);
    start_scan(2, 1);
    drive_sample(16'h0036, 2, 1);
    drive_sample(16'h0037, 2, 1);
    wait_idle("rst_rescan_idle");
    chk("rst_rescan_count", got_cnt, 64'd1);
    chk("rst_rescan_word", {32'd0, got_last}, 64'h00370036);
    $display("reset sequence: words after restart=%0d", got_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nmr_echo_packer.md
NMR_ECHO_PACKER -- requirements
Module: nmr_echo_packer

Interface
REQ-001 The block SHALL have parameter ADC_DATA_WIDTH, default 16, meaning the width of one ADC sample.
REQ-002 The block SHALL have parameter SAMPLES_PER_ECHO_WIDTH, default 32, meaning the width of the samples-per-echo count.
REQ-003 The block SHALL have parameter ECHO_PER_SCAN_WIDTH, default 32, meaning the width of the echo-per-scan count.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16, meaning the output FIFO depth in words (power of 2, ≥4).
REQ-005 Port ADC_CLK SHALL be an input of width 1: the single clock; all logic is on its rising edge.
REQ-006 Port RESET SHALL be an input of width 1: synchronous, active-high reset.
REQ-007 Port START SHALL be an input of width 1: a one-cycle pulse that arms a scan.
REQ-008 Port SAMPLES_PER_ECHO SHALL be an input of width SAMPLES_PER_ECHO_WIDTH: the number of samples per echo, latched at START.
REQ-009 Port ECHO_PER_SCAN SHALL be an input of width ECHO_PER_SCAN_WIDTH: the number of echoes per scan, latched at START.
REQ-010 Port ADC_IN_DATA SHALL be an input of width ADC_DATA_WIDTH: a sample from the NMR controller ADC stream.
REQ-011 Port ADC_IN_VALID SHALL be an input of width 1: qualifies ADC_IN_DATA; there is no back-pressure.
REQ-012 Port OUT_DATA SHALL be an output of width 2*ADC_DATA_WIDTH: a packed word, first sample in the low half.
REQ-013 Port OUT_LAST_ECHO SHALL be an output of width 1: the word is the final word of an echo.
REQ-014 Port OUT_LAST_SCAN SHALL be an output of width 1: the word is the final word of the scan.
REQ-015 Ports OUT_VALID (output, width 1) and OUT_READY (input, width 1) SHALL form the output handshake.
REQ-016 Port BUSY SHALL be an output of width 1: the state is not IDLE.
REQ-017 Port OVERFLOW SHALL be an output of width 1: a sticky flag indicating a word was dropped.

Function
REQ-018 The FSM SHALL have states IDLE, COLLECT and DRAIN.
REQ-019 On START in IDLE with both latched counts nonzero, the FSM SHALL go to COLLECT, clear both counters and clear OVERFLOW.
REQ-020 START in IDLE with either count equal to 0 SHALL be ignored: the FSM stays in IDLE and OVERFLOW is unchanged.
REQ-021 START in COLLECT or DRAIN SHALL be ignored.
REQ-022 ADC_IN_VALID SHALL be ignored in IDLE and in DRAIN.
REQ-023 In COLLECT, each valid sample SHALL advance the sample counter; even-indexed samples (0,2,…) are held, and odd-indexed samples complete the word {odd, held}.
REQ-024 On the last sample of an echo (index SAMPLES_PER_ECHO-1), a word SHALL be pushed in the same cycle; if that index is even, the word is {0, sample}.
REQ-025 On the last sample of an echo, the sample counter SHALL wrap to 0 and the echo counter SHALL increment.
REQ-026 OUT_LAST_ECHO SHALL be set on the word pushed at the last sample of each echo.
REQ-027 OUT_LAST_SCAN SHALL be set only on the last word of echo ECHO_PER_SCAN-1, and on that push the FSM SHALL go to DRAIN.
REQ-028 DRAIN SHALL go to IDLE in the cycle after the FIFO is empty, i.e. after the last accepted OUT handshake.
REQ-029 The FIFO SHALL be first-word-fall-through: a word pushed in cycle N is on OUT_VALID/OUT_DATA in cycle N+1 if the FIFO was empty.
REQ-030 While OUT_VALID=1 and OUT_READY=0, OUT_DATA and both tag outputs SHALL hold stable.
REQ-031 A pop SHALL occur when OUT_VALID and OUT_READY are both 1.
REQ-032 A push to a full FIFO in the same cycle as a pop SHALL be accepted.
REQ-033 A push to a full FIFO without a pop SHALL drop the word and set OVERFLOW.
REQ-034 After a dropped push, the counters and FSM SHALL advance as normal.
REQ-035 OVERFLOW SHALL stay set until the next accepted START or RESET.
REQ-036 The counters SHALL be at least the width of their limit port, and the comparisons SHALL be exact with no wrap before the limit.

Reset
REQ-037 On RESET=1 at a clock edge, the FSM SHALL enter IDLE, the FIFO SHALL empty, and the counters and held sample SHALL clear.
REQ-038 On reset, OUT_VALID=0, BUSY=0, OVERFLOW=0, OUT_DATA=0 and both tags=0.
REQ-039 RESET mid-scan SHALL discard all partial and queued words, and no word SHALL appear afterward until a new START.
REQ-040 RESET SHALL take priority over START and ADC_IN_VALID in the same cycle.

Structure
REQ-041 Shared package nmr_pkg SHALL hold the FSM state enum and the default widths (ADC_DATA_WIDTH, SAMPLES_PER_ECHO_WIDTH, ECHO_PER_SCAN_WIDTH, FIFO_DEPTH).
REQ-042 One sub-module, nmr_sync_fifo, SHALL be used: a single-clock FWFT FIFO of width 2*ADC_DATA_WIDTH+2 with full/empty outputs and synchronous RESET.

Verification
REQ-043 With SPE=4, EPS=2, samples 100..107 and OUT_READY=1, the outputs SHALL be words 0x00650064, 0x00670066 (LAST_ECHO), 0x00690068, 0x006B006A (LAST_ECHO, LAST_SCAN), then BUSY=0.
REQ-044 With SPE=3, EPS=1 and samples 1,2,3, the outputs SHALL be 0x00020001 then 0x00000003 with LAST_ECHO and LAST_SCAN.
REQ-045 With FIFO_DEPTH=16, OUT_READY=0, SPE=40 and EPS=1, 16 words SHALL be queued, OVERFLOW=1, then OUT_READY=1 yields exactly 16 words, the last without LAST_SCAN, and DRAIN→IDLE.
REQ-046 With SPE=0 or EPS=0 plus START, BUSY SHALL stay 0 and no OUT_VALID appears for 50 cycles of valid samples.
REQ-047 A RESET pulse after 5 of 8 samples SHALL give OUT_VALID=0 the next cycle, and a new START with SPE=2, EPS=1 SHALL yield exactly one word.
REQ-048 With OUT_READY toggling every cycle during a full FIFO with simultaneous push, no word SHALL be lost or duplicated and OVERFLOW SHALL stay 0.
